// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data memory arbiter
package dmem_arb_pkg;

  typedef enum logic {
    OPEN,
    LOCKED
  } state_e;

  localparam logic OWN_C = 1'b0;
  localparam logic OWN_L = 1'b1;

  localparam int MASK_W       = 4;
  localparam int DEF_MAX_WAIT = 4;
  localparam int DEF_LOCK_MAX = 16;

endpackage

// File: rtl/arb_sat_counter.sv
// rtl/arb_sat_counter.sv - saturating up-counter with synchronous clear
module arb_sat_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // clear wins over increment so a grant and a loss in the same cycle cannot both count
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != W'(MAX))) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter sharing datamem between the core and a loader/debug master
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic [MASK_W-1:0] c_mask,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic [MASK_W-1:0] l_mask,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              m_load,
  output logic              m_store,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [MASK_W-1:0] m_mask,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int LOCK_W = $clog2(LOCK_MAX + 1);

  state_e            state, state_nxt;
  logic [WAIT_W-1:0] l_wait;
  logic [LOCK_W-1:0] lock_cnt;
  logic              rd_pend, rd_owner;
  logic              wait_full, lock_full, lock_grant;

  assign wait_full  = (l_wait == WAIT_W'(MAX_WAIT));
  assign lock_full  = (lock_cnt == LOCK_W'(LOCK_MAX));
  assign lock_grant = l_gnt & l_lock;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= OPEN;
    end else begin
      state <= state_nxt;
    end
  end

  // Any cycle without a locked loader grant drops back to OPEN
  always_comb begin
    c_gnt     = 1'b0;
    l_gnt     = 1'b0;
    state_nxt = OPEN;
    case (state)
      OPEN: begin
        if (c_req && l_req) begin
          if (wait_full) l_gnt = 1'b1;
          else           c_gnt = 1'b1;
        end else begin
          c_gnt = c_req;
          l_gnt = l_req;
        end
      end
      LOCKED: begin
        if (l_req) begin
          if (lock_full && c_req) c_gnt = 1'b1;
          else                    l_gnt = 1'b1;
        end else begin
          c_gnt = c_req;
        end
      end
      default: begin
      end
    endcase
    if (l_gnt && l_lock) state_nxt = LOCKED;
  end

  // l_wait counts consecutive lost cycles; a cancelled request starts over
  arb_sat_counter #(
    .MAX (MAX_WAIT),
    .W   (WAIT_W)
  ) u_wait (
    .clk   (clk),
    .rst   (rst),
    .clr   (l_gnt | ~l_req),
    .inc   (l_req & ~l_gnt),
    .count (l_wait)
  );

  // lock_cnt is 0 in OPEN, so the first locked grant lands on 1
  arb_sat_counter #(
    .MAX (LOCK_MAX),
    .W   (LOCK_W)
  ) u_lock (
    .clk   (clk),
    .rst   (rst),
    .clr   (~lock_grant),
    .inc   (lock_grant),
    .count (lock_cnt)
  );

  always_comb begin
    m_load  = 1'b0;
    m_store = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_mask  = '0;
    if (c_gnt) begin
      m_load  = ~c_we;
      m_store = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
      m_mask  = c_mask;
    end else if (l_gnt) begin
      m_load  = ~l_we;
      m_store = l_we;
      m_addr  = l_addr;
      m_wdata = l_wdata;
      m_mask  = l_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_pend  <= 1'b0;
      rd_owner <= OWN_C;
    end else begin
      rd_pend <= m_load;
      if (m_load) rd_owner <= l_gnt ? OWN_L : OWN_C;
    end
  end

  assign c_rvalid = rd_pend && (rd_owner == OWN_C);
  assign l_rvalid = rd_pend && (rd_owner == OWN_L);
  assign c_rdata  = m_rdata;
  assign l_rdata  = m_rdata;
  assign c_stall  = c_req & ~c_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter with a cycle-level reference model
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam int LOCK_MAX = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              c_req, c_we, l_req, l_we, l_lock;
  logic [ADDR_W-1:0] c_addr, l_addr, m_addr;
  logic [DATA_W-1:0] c_wdata, l_wdata, m_wdata, c_rdata, l_rdata;
  logic [DATA_W-1:0] m_rdata = '0;
  logic [3:0]        c_mask, l_mask, m_mask;
  logic              c_gnt, c_rvalid, c_stall, l_gnt, l_rvalid, m_load, m_store;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_mask   (c_mask),
    .c_gnt    (c_gnt),
    .c_rvalid (c_rvalid),
    .c_rdata  (c_rdata),
    .c_stall  (c_stall),
    .l_req    (l_req),
    .l_we     (l_we),
    .l_addr   (l_addr),
    .l_wdata  (l_wdata),
    .l_mask   (l_mask),
    .l_lock   (l_lock),
    .l_gnt    (l_gnt),
    .l_rvalid (l_rvalid),
    .l_rdata  (l_rdata),
    .m_load   (m_load),
    .m_store  (m_store),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_mask   (m_mask),
    .m_rdata  (m_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 4) return 32'hDEADBEEF;
    return {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] mk);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (mk[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Stand-in for datamem: one-cycle read latency, byte-masked writes
  logic [31:0] datamem [256];
  bit          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) datamem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else begin
      if (m_load)  m_rdata <= datamem[m_addr];
      if (m_store) datamem[m_addr] <= merge(datamem[m_addr], m_wdata, m_mask);
    end
  end

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
  } rd_t;

  logic [31:0] ref_mem [256];
  rd_t         rdq[$];
  int          wait_lost, lock_run;
  int          n_checks = 0;
  int          n_pass = 0;
  int          nw, lock_pct;
  bit          exp_cg, exp_lg, core_done;
  bit          obs_cg, obs_lg, obs_stall, obs_crv, obs_lrv;
  logic [31:0] obs_crd, obs_lrd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0; c_mask = '0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0; l_mask = '0; l_lock = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_lost = 0;
    lock_run  = 0;
    exp_cg    = 1'b0;
    exp_lg    = 1'b0;
    rdq.delete();
  endtask

  task automatic post_reset_checks();
    #1;
    check("rst_c_gnt", c_gnt, 1'b0);
    check("rst_l_gnt", l_gnt, 1'b0);
    check("rst_c_rvalid", c_rvalid, 1'b0);
    check("rst_l_rvalid", l_rvalid, 1'b0);
    check("rst_m_load", m_load, 1'b0);
    check("rst_m_store", m_store, 1'b0);
    check("rst_m_addr", m_addr, 8'h00);
    check("rst_state", dut.state, OPEN);
  endtask

  // One bus cycle: inputs are already applied; check against the model, then advance
  task automatic step();
    rd_t         r;
    bit          ecg, elg, exp_crv, exp_lrv, ewe;
    logic [7:0]  eaddr;
    logic [31:0] ewd, exp_rd;
    logic [3:0]  emk;
    #2;
    exp_crv = 1'b0; exp_lrv = 1'b0; exp_rd = '0;
    if (rdq.size() > 0) begin
      r = rdq.pop_front();
      exp_crv = (r.owner == OWN_C);
      exp_lrv = (r.owner == OWN_L);
      exp_rd  = r.data;
    end
    obs_cg = c_gnt; obs_lg = l_gnt; obs_stall = c_stall;
    obs_crv = c_rvalid; obs_lrv = l_rvalid; obs_crd = c_rdata; obs_lrd = l_rdata;
    check("c_rvalid", c_rvalid, exp_crv);
    check("l_rvalid", l_rvalid, exp_lrv);
    if (exp_crv) check("c_rdata", c_rdata, exp_rd);
    if (exp_lrv) check("l_rdata", l_rdata, exp_rd);

    if (c_req && l_req) begin
      if (lock_run > 0) elg = (lock_run < LOCK_MAX);
      else              elg = (wait_lost == MAX_WAIT);
      ecg = !elg;
    end else begin
      ecg = c_req;
      elg = l_req;
    end
    ewe = 1'b0; eaddr = '0; ewd = '0; emk = '0;
    if (ecg) begin
      ewe = c_we; eaddr = c_addr; ewd = c_wdata; emk = c_mask;
    end else if (elg) begin
      ewe = l_we; eaddr = l_addr; ewd = l_wdata; emk = l_mask;
    end
    check("c_gnt", c_gnt, ecg);
    check("l_gnt", l_gnt, elg);
    check("c_stall", c_stall, c_req && !ecg);
    check("m_load", m_load, (ecg || elg) && !ewe);
    check("m_store", m_store, (ecg || elg) && ewe);
    check("m_addr", m_addr, eaddr);
    check("m_wdata", m_wdata, ewd);
    check("m_mask", m_mask, emk);

    if ((ecg || elg) && !ewe) begin
      r.owner = elg ? OWN_L : OWN_C;
      r.data  = ref_mem[eaddr];
      rdq.push_back(r);
    end
    if ((ecg || elg) && ewe) ref_mem[eaddr] = merge(ref_mem[eaddr], ewd, emk);
    wait_lost = (l_req && !elg) ? ((wait_lost < MAX_WAIT) ? wait_lost + 1 : MAX_WAIT) : 0;
    lock_run  = (elg && l_lock) ? ((lock_run < LOCK_MAX) ? lock_run + 1 : LOCK_MAX) : 0;
    exp_cg = ecg;
    exp_lg = elg;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    rst = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    post_reset_checks();

    // core alone
    c_req = 1'b1; c_addr = 8'h04;
    step();
    check("alone_gnt", obs_cg, 1'b1);
    check("alone_stall", obs_stall, 1'b0);
    idle_inputs();
    step();
    check("alone_rvalid", obs_crv, 1'b1);
    check("alone_rdata", obs_crd, 32'hDEADBEEF);
    check("alone_stall2", obs_stall, 1'b0);

    // reset while a read is in flight
    c_req = 1'b1; c_addr = 8'h10;
    step();
    do_reset();
    post_reset_checks();
    step();
    check("midread_no_rvalid", obs_crv, 1'b0);

    // continuous contention without lock
    c_req = 1'b1; c_addr = 8'h05; l_req = 1'b1; l_addr = 8'h20;
    for (int i = 0; i < 10; i++) begin
      step();
      check("starve_cgnt", obs_cg, (i % 5) != 4);
      check("starve_lgnt", obs_lg, (i % 5) == 4);
      check("starve_stall", obs_stall, (i % 5) == 4);
    end

    // locked loader burst of 20 stores against a requesting core
    idle_inputs();
    c_addr = 8'h04; l_req = 1'b1; l_we = 1'b1; l_lock = 1'b1; l_mask = 4'hF;
    nw = 0; core_done = 1'b0;
    for (int i = 0; i < 24 && nw < 20; i++) begin
      l_addr  = 8'(64 + nw);
      l_wdata = {24'hC0FFEE, 8'(nw)};
      c_req   = (i >= 1) && !core_done;
      step();
      if (exp_lg) nw++;
      if (exp_cg) core_done = 1'b1;
      check("lock_lgnt", obs_lg, i != 16);
      check("lock_cgnt", obs_cg, i == 16);
    end
    check("lock_words", nw, 20);
    idle_inputs();
    step();

    // core store then loader load of the same word
    c_req = 1'b1; c_we = 1'b1; c_addr = 8'h08; c_wdata = 32'h12345678; c_mask = 4'hF;
    step();
    idle_inputs();
    l_req = 1'b1; l_addr = 8'h08;
    step();
    check("b2b_lgnt", obs_lg, 1'b1);
    idle_inputs();
    step();
    check("b2b_lrvalid", obs_lrv, 1'b1);
    check("b2b_lrdata", obs_lrd, 32'h12345678);
    check("b2b_crvalid", obs_crv, 1'b0);

    // loader cancels after two lost cycles; wait count must restart
    do_reset();
    c_req = 1'b1; c_addr = 8'h04; l_req = 1'b1; l_addr = 8'h20;
    step(); check("cancel_lost1", obs_lg, 1'b0);
    step(); check("cancel_lost2", obs_lg, 1'b0);
    l_req = 1'b0;
    step(); check("cancel_idle", obs_lg, 1'b0);
    check("cancel_wait", dut.l_wait, 0);
    l_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("cancel_cgnt", obs_cg, i < 4);
    end

    // randomized traffic obeying the hold-until-grant rule
    idle_inputs();
    lock_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) lock_pct = $urandom_range(0, 100);
      if ($urandom_range(0, 999) == 0) do_reset();
      if (c_req && !exp_cg) begin
        if ($urandom_range(0, 7) == 0) c_req = 1'b0;
      end else begin
        c_req   = ($urandom_range(0, 99) < 60);
        c_we    = 1'($urandom);
        c_addr  = 8'($urandom_range(0, 15));
        c_wdata = $urandom;
        c_mask  = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom);
      end
      if (l_req && !exp_lg) begin
        if ($urandom_range(0, 7) == 0) l_req = 1'b0;
      end else begin
        l_req   = ($urandom_range(0, 99) < 60);
        l_we    = 1'($urandom);
        l_addr  = 8'($urandom_range(0, 15));
        l_wdata = $urandom;
        l_mask  = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom);
        l_lock  = ($urandom_range(0, 99) < lock_pct);
      end
      step();
    end
    idle_inputs();
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
